// File: rtl/crgu_pkg.sv
// -----------------------------------------------------------------------------
// crgu_pkg
// Shared types and default constants for the CRGU clock-gate / reset
// sequencer.
//   seq_state_e    : sequencer FSM states
//   CRGU_CNT_W     : default width of the sequencing counter
//   CRGU_PRE_CYC   : default cycles the clock runs before reset release
//   CRGU_HOLD_CYC  : default cycles reset is held with the clock running
//   CRGU_MAX_NCH   : largest supported number of gated domains
// -----------------------------------------------------------------------------
package crgu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_SRST = 2'd3
    } seq_state_e;

    localparam int CRGU_CNT_W    = 4;
    localparam int CRGU_PRE_CYC  = 4;
    localparam int CRGU_HOLD_CYC = 8;
    localparam int CRGU_MAX_NCH  = 16;

endpackage

// File: rtl/crgu_sync.sv
// -----------------------------------------------------------------------------
// crgu_sync
// WIDTH-wide, STAGES-deep flop synchroniser with asynchronous active-low
// reset. Each bit is synchronised independently.
//   clk     in   1      destination clock
//   rst_n   in   1      asynchronous active-low reset (all stages clear to 0)
//   async_i in   WIDTH  asynchronous level inputs
//   sync_o  out  WIDTH  synchronised outputs (last stage)
// -----------------------------------------------------------------------------
module crgu_sync
    import crgu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    always_comb begin
        stage_d[0] = async_i;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign sync_o = stage_q[STAGES-1];

endmodule

// File: rtl/crgu_seq.sv
// -----------------------------------------------------------------------------
// crgu_seq
// Per-domain clock-gate / reset sequencer. Level requests are synchronised,
// compared against the current ready state, and any mismatching domain is
// sequenced one at a time (lowest index first):
//   power-up  : clock enable, PRE_CYC cycles later reset release + ready
//   power-down: reset assert + not ready, HOLD_CYC cycles later clock gate
// A soft-reset pulse schedules a global pass that holds every domain reset
// for HOLD_CYC cycles and then releases the ones whose clock is running.
//   clk_crg    in   1    sequencer clock
//   rst_crg_n  in   1    asynchronous active-low reset
//   scan_mode  in   1    forces all clock enables on, resets follow rst_crg_n
//   ch_req     in   NCH  per-domain enable request (async level)
//   soft_rst   in   1    single-cycle soft-reset pulse (sync to clk_crg)
//   clk_en_o   out  NCH  clock-gate enable per domain
//   rst_n_o    out  NCH  active-low reset per domain
//   ch_rdy     out  NCH  domain clocked and out of reset
//   busy       out  1    sequence running or soft reset pending
// -----------------------------------------------------------------------------
module crgu_seq
    import crgu_pkg::*;
#(
    parameter int NCH         = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PRE_CYC     = CRGU_PRE_CYC,
    parameter int HOLD_CYC    = CRGU_HOLD_CYC,
    parameter int CNT_W       = CRGU_CNT_W
) (
    input  logic           clk_crg,
    input  logic           rst_crg_n,
    input  logic           scan_mode,
    input  logic [NCH-1:0] ch_req,
    input  logic           soft_rst,
    output logic [NCH-1:0] clk_en_o,
    output logic [NCH-1:0] rst_n_o,
    output logic [NCH-1:0] ch_rdy,
    output logic           busy
);

    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    // Reject parameter sets the counter or index logic cannot represent.
    generate
        if (NCH < 1 || NCH > CRGU_MAX_NCH) begin : g_bad_nch
            $error("crgu_seq: NCH out of range 1..16");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("crgu_seq: SYNC_STAGES must be >= 2");
        end
        if (PRE_CYC < 1 || PRE_CYC > (2**CNT_W) - 1) begin : g_bad_pre
            $error("crgu_seq: PRE_CYC out of range 1..2**CNT_W-1");
        end
        if (HOLD_CYC < 1 || HOLD_CYC > (2**CNT_W) - 1) begin : g_bad_hold
            $error("crgu_seq: HOLD_CYC out of range 1..2**CNT_W-1");
        end
    endgenerate

    // Lowest set bit wins so simultaneous requests are served in index order.
    function automatic logic [IDX_W-1:0] lowest_index(input logic [NCH-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    logic [NCH-1:0]   req_s;
    logic [NCH-1:0]   mismatch;
    logic [IDX_W-1:0] pick;

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [NCH-1:0]   clk_en_q, clk_en_d;
    logic [NCH-1:0]   rst_n_q, rst_n_d;
    logic [NCH-1:0]   rdy_q, rdy_d;
    logic             srst_pend_q, srst_pend_d;
    logic             busy_q, busy_d;

    crgu_sync #(
        .WIDTH  (NCH),
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk     (clk_crg),
        .rst_n   (rst_crg_n),
        .async_i (ch_req),
        .sync_o  (req_s)
    );

    assign mismatch = req_s ^ rdy_q;
    assign pick     = lowest_index(mismatch);

    // Next-state logic. The counter is only loaded on entry to a timed state
    // and only decremented while non-zero, so it can never wrap.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        clk_en_d    = clk_en_q;
        rst_n_d     = rst_n_q;
        rdy_d       = rdy_q;
        srst_pend_d = srst_pend_q;
        busy_d      = (state_q != S_IDLE) || srst_pend_q;

        case (state_q)
            S_IDLE: begin
                if (srst_pend_q) begin
                    state_d     = S_SRST;
                    rst_n_d     = '0;
                    rdy_d       = '0;
                    cnt_d       = CNT_W'(HOLD_CYC - 1);
                    srst_pend_d = 1'b0;
                end else if (|mismatch) begin
                    sel_d = pick;
                    if (req_s[pick]) begin
                        state_d        = S_ON;
                        clk_en_d[pick] = 1'b1;
                        cnt_d          = CNT_W'(PRE_CYC - 1);
                    end else begin
                        state_d       = S_OFF;
                        rst_n_d[pick] = 1'b0;
                        rdy_d[pick]   = 1'b0;
                        cnt_d         = CNT_W'(HOLD_CYC - 1);
                    end
                end
            end
            S_ON: begin
                if (cnt_q == '0) begin
                    rst_n_d[sel_q] = 1'b1;
                    rdy_d[sel_q]   = 1'b1;
                    state_d        = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_OFF: begin
                if (cnt_q == '0) begin
                    clk_en_d[sel_q] = 1'b0;
                    state_d         = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SRST: begin
                // Only domains whose clock is running may leave reset.
                if (cnt_q == '0) begin
                    rst_n_d = clk_en_q;
                    rdy_d   = clk_en_q;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new pulse outranks the clear-on-entry so a pulse arriving while
        // a pass starts still earns one more pass.
        if (soft_rst) begin
            srst_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_crg or negedge rst_crg_n) begin
        if (!rst_crg_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sel_q       <= '0;
            clk_en_q    <= '0;
            rst_n_q     <= '0;
            rdy_q       <= '0;
            srst_pend_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            clk_en_q    <= clk_en_d;
            rst_n_q     <= rst_n_d;
            rdy_q       <= rdy_d;
            srst_pend_q <= srst_pend_d;
            busy_q      <= busy_d;
        end
    end

    // Scan bypass is purely combinational so the test clock reaches every
    // domain and resets are controlled directly from the tester.
    assign clk_en_o = scan_mode ? {NCH{1'b1}} : clk_en_q;
    assign rst_n_o  = scan_mode ? {NCH{rst_crg_n}} : rst_n_q;
    assign ch_rdy   = rdy_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_crgu_seq.sv
// -----------------------------------------------------------------------------
// tb_crgu_seq
// Directed testbench for crgu_seq (NCH=4, SYNC_STAGES=2, PRE_CYC=4,
// HOLD_CYC=8). Stimulus pushes every expected output change, with the cycle
// it must appear in, into a queue; a monitor compares each observed change of
// {busy, clk_en_o, rst_n_o, ch_rdy} against the head of the queue and also
// checks the reset-implies-clock invariant every cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_crgu_seq;

    logic       clk_crg = 1'b0;
    logic       rst_crg_n;
    logic       scan_mode;
    logic [3:0] ch_req;
    logic       soft_rst;
    logic [3:0] clk_en_o;
    logic [3:0] rst_n_o;
    logic [3:0] ch_rdy;
    logic       busy;

    typedef struct {
        int          cycle;
        logic [12:0] vec;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          base_cyc = 0;
    int          tests_run = 0;
    int          fail_count = 0;
    logic        mon_on = 1'b0;
    logic [12:0] prev_vec = '0;

    crgu_seq #(
        .NCH         (4),
        .SYNC_STAGES (2),
        .PRE_CYC     (4),
        .HOLD_CYC    (8),
        .CNT_W       (4)
    ) dut (
        .clk_crg   (clk_crg),
        .rst_crg_n (rst_crg_n),
        .scan_mode (scan_mode),
        .ch_req    (ch_req),
        .soft_rst  (soft_rst),
        .clk_en_o  (clk_en_o),
        .rst_n_o   (rst_n_o),
        .ch_rdy    (ch_rdy),
        .busy      (busy)
    );

    // ~6.5 MHz sequencer clock
    always #77 clk_crg = ~clk_crg;

    always @(posedge clk_crg) cyc <= cyc + 1;

    // Monitor: every change of the output vector must match the next
    // expected entry, both in value and in cycle.
    always @(negedge clk_crg) begin : monitor
        logic [12:0] cur;
        exp_t        e;
        if (mon_on && !scan_mode) begin
            cur = {busy, clk_en_o, rst_n_o, ch_rdy};
            tests_run++;
            if ((rst_n_o & ~clk_en_o) != 4'b0000) begin
                fail_count++;
                $display("[TB] FAIL invariant @%0d: rst_n_o=%b with clk_en_o=%b", cyc, rst_n_o, clk_en_o);
            end
            while (exp_q.size() > 0 && exp_q[0].cycle < cyc) begin
                e = exp_q.pop_front();
                tests_run++;
                fail_count++;
                $display("[TB] FAIL %s: no change at cycle %0d, got %b required %b", e.name, e.cycle, cur, e.vec);
            end
            if (cur != prev_vec) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    fail_count++;
                    $display("[TB] FAIL unexpected @%0d: got %b was %b", cyc, cur, prev_vec);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cycle != cyc || e.vec != cur) begin
                        fail_count++;
                        $display("[TB] FAIL %s: got %b at cycle %0d, required %b at cycle %0d", e.name, cur, cyc, e.vec, e.cycle);
                    end
                end
            end
            prev_vec = cur;
        end
    end

    function automatic void push_exp(input string name, input int off, input logic b,
                                     input logic [3:0] en, input logic [3:0] rst, input logic [3:0] rdy);
        exp_t e;
        e.cycle = base_cyc + off;
        e.vec   = {b, en, rst, rdy};
        e.name  = name;
        exp_q.push_back(e);
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_crg);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] req);
        wait_cycles(1);
        base_cyc = cyc;
        ch_req   = req;
    endtask

    task automatic applySoft();
        wait_cycles(1);
        base_cyc = cyc;
        soft_rst = 1'b1;
        wait_cycles(1);
        soft_rst = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic b, input logic [3:0] en,
                               input logic [3:0] rst, input logic [3:0] rdy);
        tests_run++;
        if ({busy, clk_en_o, rst_n_o, ch_rdy} != {b, en, rst, rdy}) begin
            fail_count++;
            $display("[TB] FAIL %s: got busy=%b en=%b rst_n=%b rdy=%b, required busy=%b en=%b rst_n=%b rdy=%b",
                     name, busy, clk_en_o, rst_n_o, ch_rdy, b, en, rst, rdy);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            wait_cycles(1);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests_run++;
            fail_count++;
            $display("[TB] FAIL %s: timeout, %0d expected changes pending", name, exp_q.size());
            exp_q.delete();
        end
        wait_cycles(4);
    endtask

    initial begin
        rst_crg_n = 1'b1;
        scan_mode = 1'b0;
        ch_req    = 4'b0000;
        soft_rst  = 1'b0;
        #1 rst_crg_n = 1'b0;
        wait_cycles(3);
        rst_crg_n = 1'b1;
        checkOutput("reset_state", 1'b0, 4'b0000, 4'b0000, 4'b0000);
        prev_vec = '0;
        mon_on   = 1'b1;

        // 1: idle after reset
        wait_cycles(50);
        checkOutput("idle_50", 1'b0, 4'b0000, 4'b0000, 4'b0000);

        // 2: power up ch0
        applyStimulus(4'b0001);
        push_exp("on0_clk",  3, 1'b0, 4'b0001, 4'b0000, 4'b0000);
        push_exp("on0_busy", 4, 1'b1, 4'b0001, 4'b0000, 4'b0000);
        push_exp("on0_rdy",  7, 1'b1, 4'b0001, 4'b0001, 4'b0001);
        push_exp("on0_done", 8, 1'b0, 4'b0001, 4'b0001, 4'b0001);
        wait_idle("on0");

        // 4: power down ch0
        applyStimulus(4'b0000);
        push_exp("off0_rst",  3,  1'b0, 4'b0001, 4'b0000, 4'b0000);
        push_exp("off0_busy", 4,  1'b1, 4'b0001, 4'b0000, 4'b0000);
        push_exp("off0_gate", 11, 1'b1, 4'b0000, 4'b0000, 4'b0000);
        push_exp("off0_done", 12, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        wait_idle("off0");

        // 3: two simultaneous requests, ch1 first then ch3
        applyStimulus(4'b1010);
        push_exp("dual_ch1_clk",  3,  1'b0, 4'b0010, 4'b0000, 4'b0000);
        push_exp("dual_ch1_busy", 4,  1'b1, 4'b0010, 4'b0000, 4'b0000);
        push_exp("dual_ch1_rdy",  7,  1'b1, 4'b0010, 4'b0010, 4'b0010);
        push_exp("dual_ch3_clk",  8,  1'b0, 4'b1010, 4'b0010, 4'b0010);
        push_exp("dual_ch3_busy", 9,  1'b1, 4'b1010, 4'b0010, 4'b0010);
        push_exp("dual_ch3_rdy",  12, 1'b1, 4'b1010, 4'b1010, 4'b1010);
        push_exp("dual_done",     13, 1'b0, 4'b1010, 4'b1010, 4'b1010);
        wait_idle("dual");

        // async reset with everything up
        wait_cycles(1);
        base_cyc  = cyc;
        rst_crg_n = 1'b0;
        ch_req    = 4'b0000;
        push_exp("async_rst", 1, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        wait_cycles(2);
        rst_crg_n = 1'b1;
        wait_idle("async_rst");

        // bring up ch0 and ch2
        applyStimulus(4'b0101);
        push_exp("up02_c0",   3,  1'b0, 4'b0001, 4'b0000, 4'b0000);
        push_exp("up02_b0",   4,  1'b1, 4'b0001, 4'b0000, 4'b0000);
        push_exp("up02_r0",   7,  1'b1, 4'b0001, 4'b0001, 4'b0001);
        push_exp("up02_c2",   8,  1'b0, 4'b0101, 4'b0001, 4'b0001);
        push_exp("up02_b2",   9,  1'b1, 4'b0101, 4'b0001, 4'b0001);
        push_exp("up02_r2",   12, 1'b1, 4'b0101, 4'b0101, 4'b0101);
        push_exp("up02_done", 13, 1'b0, 4'b0101, 4'b0101, 4'b0101);
        wait_idle("up02");

        // 5: soft reset with ch0/ch2 ready
        applySoft();
        push_exp("srst_enter",   2,  1'b1, 4'b0101, 4'b0000, 4'b0000);
        push_exp("srst_release", 10, 1'b1, 4'b0101, 4'b0101, 4'b0101);
        push_exp("srst_done",    11, 1'b0, 4'b0101, 4'b0101, 4'b0101);
        wait_idle("srst");

        // 6a: soft reset during power-up of ch1
        applyStimulus(4'b0111);
        push_exp("on1_clk",      3,  1'b0, 4'b0111, 4'b0101, 4'b0101);
        push_exp("on1_busy",     4,  1'b1, 4'b0111, 4'b0101, 4'b0101);
        push_exp("on1_rdy",      7,  1'b1, 4'b0111, 4'b0111, 4'b0111);
        push_exp("on1_srst",     8,  1'b1, 4'b0111, 4'b0000, 4'b0000);
        push_exp("on1_srst_rel", 16, 1'b1, 4'b0111, 4'b0111, 4'b0111);
        push_exp("on1_done",     17, 1'b0, 4'b0111, 4'b0111, 4'b0111);
        wait_cycles(4);
        soft_rst = 1'b1;
        wait_cycles(1);
        soft_rst = 1'b0;
        wait_idle("on1_srst");

        // 6b: async reset in the middle of powering down ch2
        applyStimulus(4'b0011);
        push_exp("off2_rst",  3, 1'b0, 4'b0111, 4'b0011, 4'b0011);
        push_exp("off2_busy", 4, 1'b1, 4'b0111, 4'b0011, 4'b0011);
        push_exp("off2_abort", 7, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        wait_cycles(6);
        rst_crg_n = 1'b0;
        ch_req    = 4'b0000;
        wait_cycles(3);
        rst_crg_n = 1'b1;
        wait_idle("off2_abort");

        // scan bypass
        scan_mode = 1'b1;
        #1 checkOutput("scan_on", 1'b0, 4'b1111, 4'b1111, 4'b0000);
        rst_crg_n = 1'b0;
        #1 checkOutput("scan_rst", 1'b0, 4'b1111, 4'b0000, 4'b0000);
        rst_crg_n = 1'b1;
        #1 scan_mode = 1'b0;
        #1 checkOutput("scan_off", 1'b0, 4'b0000, 4'b0000, 4'b0000);
        wait_cycles(10);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
